// File: rtl/itch_add_order_encoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// itch_add_order_encoder
//
// Serializes one ITCH 5.0 Add Order ('A') message, presented as a parallel
// field bundle, into a 36-byte big-endian byte stream. Used as the transmit
// stimulus / loopback source for the ITCH decoder pipeline and its watchdog.
//
// Wire order (MSB first per field):
//   type, stock_locate, tracking_number, timestamp, order_ref, side, shares,
//   stock, price  -> 1+2+2+6+8+1+4+8+4 = 36 bytes
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   field bundle handshake (accept only in IDLE)
//   stock_locate .. price  message fields, sampled only on accept
//   abort               drop the message in flight (SEND/GAP only)
//   out_ready           downstream byte acceptance
//   valid_out, byte_out, byte_index  registered byte stream, holds on stall
//   start_of_msg        high with the index-0 byte
//   end_of_msg          high with the index MSG_LEN-1 byte
//   busy                encoder not IDLE
//   msg_count           completed messages (wraps)
//   abort_count         aborted messages (wraps)
// -----------------------------------------------------------------------------
module itch_add_order_encoder #(
   parameter int         MSG_LEN     = 36,
   parameter int         INDEX_WIDTH = 6,
   parameter logic [7:0] MSG_TYPE    = 8'h41,
   parameter int         GAP_CYCLES  = 0,
   parameter int         CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [15:0]            stock_locate,
   input  logic [15:0]            tracking_number,
   input  logic [47:0]            timestamp,
   input  logic [63:0]            order_ref,
   input  logic [7:0]             side,
   input  logic [31:0]            shares,
   input  logic [63:0]            stock,
   input  logic [31:0]            price,
   input  logic                   abort,
   input  logic                   out_ready,
   output logic                   valid_out,
   output logic [7:0]             byte_out,
   output logic [INDEX_WIDTH-1:0] byte_index,
   output logic                   start_of_msg,
   output logic                   end_of_msg,
   output logic                   busy,
   output logic [CNT_WIDTH-1:0]   msg_count,
   output logic [CNT_WIDTH-1:0]   abort_count
);

   localparam int                     SHIFT_W    = 8 * MSG_LEN;
   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(MSG_LEN - 1);
   // GAP is unreachable when GAP_CYCLES is 0, so the terminal count is moot.
   localparam logic [3:0]             GAP_LAST   = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [SHIFT_W-1:0]     r_shift;
   logic [INDEX_WIDTH-1:0] r_index;
   logic [INDEX_WIDTH-1:0] w_next_index;
   logic [3:0]             r_gap_cnt;
   logic                   r_valid_out;
   logic                   r_in_ready;
   logic                   r_start;
   logic                   r_end;
   logic                   r_busy;
   logic [CNT_WIDTH-1:0]   r_msg_count;
   logic [CNT_WIDTH-1:0]   r_abort_count;

   logic                   w_accept;
   logic                   w_shift;
   logic                   w_msg_done;
   logic                   w_abort_send;

   // Next-state logic. valid_out is high for the whole of SEND, so a transfer
   // in SEND is simply out_ready. An end-byte transfer wins over abort.
   always_comb begin
      // NOTE: every signal driven here gets a default first; a branch that
      // forgets one would otherwise infer a latch.
      w_next_state = r_state;
      w_next_index = r_index;
      w_accept     = 1'b0;
      w_shift      = 1'b0;
      w_msg_done   = 1'b0;
      w_abort_send = 1'b0;
      case (r_state)
         S_IDLE: begin
            // abort is deliberately ignored here.
            if (in_valid && r_in_ready) begin
               w_accept     = 1'b1;
               w_next_state = S_SEND;
               w_next_index = '0;
            end
         end
         S_SEND: begin
            if (out_ready && (r_index == LAST_INDEX)) begin
               w_msg_done   = 1'b1;
               w_next_state = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end else if (abort) begin
               w_abort_send = 1'b1;
               w_next_state = S_IDLE;
            end else if (out_ready) begin
               w_shift      = 1'b1;
               w_next_index = r_index + INDEX_WIDTH'(1);
            end
         end
         S_GAP: begin
            if (abort || (r_gap_cnt == GAP_LAST)) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs. Output flags are computed from
   // the next state so they line up with the byte they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         // NOTE: the shift register is cleared on reset because its top byte
         // drives byte_out directly and must read 0 after reset.
         r_shift       <= '0;
         r_index       <= '0;
         r_gap_cnt     <= '0;
         r_valid_out   <= 1'b0;
         r_in_ready    <= 1'b0;
         r_start       <= 1'b0;
         r_end         <= 1'b0;
         r_busy        <= 1'b0;
         r_msg_count   <= '0;
         r_abort_count <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register
         // samples the pre-edge values regardless of statement order.
         r_state <= w_next_state;
         r_index <= w_next_index;

         if (w_accept) begin
            r_shift <= {MSG_TYPE, stock_locate, tracking_number, timestamp,
                        order_ref, side, shares, stock, price};
         end else if (w_shift) begin
            r_shift <= {r_shift[SHIFT_W-9:0], 8'h00};
         end

         if (r_state == S_GAP) begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
         end else begin
            r_gap_cnt <= '0;
         end

         r_valid_out <= (w_next_state == S_SEND);
         r_in_ready  <= (w_next_state == S_IDLE);
         r_busy      <= (w_next_state != S_IDLE);
         r_start     <= (w_next_state == S_SEND) && (w_next_index == '0);
         r_end       <= (w_next_state == S_SEND) && (w_next_index == LAST_INDEX);

         if (w_msg_done) begin
            r_msg_count <= r_msg_count + CNT_WIDTH'(1);
         end
         if (w_abort_send) begin
            r_abort_count <= r_abort_count + CNT_WIDTH'(1);
         end
      end
   end

   assign in_ready     = r_in_ready;
   assign valid_out    = r_valid_out;
   assign byte_out     = r_shift[SHIFT_W-1 -: 8];
   assign byte_index   = r_index;
   assign start_of_msg = r_start;
   assign end_of_msg   = r_end;
   assign busy         = r_busy;
   assign msg_count    = r_msg_count;
   assign abort_count  = r_abort_count;

endmodule

// File: tb/tb_itch_add_order_encoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_itch_add_order_encoder
//
// Self-checking bench for itch_add_order_encoder. Expected bytes are pushed to
// a scoreboard queue when a bundle is accepted and popped by a monitor on every
// byte transfer. A second instance with GAP_CYCLES=4 covers the idle gap.
// -----------------------------------------------------------------------------
module tb_itch_add_order_encoder;

   localparam int IW = 6;
   localparam int CW = 16;

   typedef struct packed {
      logic [15:0] sl;
      logic [15:0] tn;
      logic [47:0] ts;
      logic [63:0] oref;
      logic [7:0]  side;
      logic [31:0] shares;
      logic [63:0] stock;
      logic [31:0] price;
   } fields_t;

   typedef struct {
      logic [7:0]    b;
      logic [IW-1:0] idx;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   fields_t       fld;

   logic          in_valid, in_ready, abort, out_ready;
   logic          valid_out, start_of_msg, end_of_msg, busy;
   logic [7:0]    byte_out;
   logic [IW-1:0] byte_index;
   logic [CW-1:0] msg_count, abort_count;

   logic          g_in_valid, g_in_ready, g_abort, g_out_ready;
   logic          g_valid_out, g_start, g_end, g_busy;
   logic [7:0]    g_byte_out;
   logic [IW-1:0] g_byte_index;
   logic [CW-1:0] g_msg_count, g_abort_count;

   exp_t          q[$];
   longint        st_cyc[$];
   longint        cyc = 0;
   int            n_checks = 0;
   int            n_errors = 0;
   int            n_bytes = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   itch_add_order_encoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .stock_locate(fld.sl), .tracking_number(fld.tn), .timestamp(fld.ts),
      .order_ref(fld.oref), .side(fld.side), .shares(fld.shares),
      .stock(fld.stock), .price(fld.price), .abort(abort), .out_ready(out_ready),
      .valid_out(valid_out), .byte_out(byte_out), .byte_index(byte_index),
      .start_of_msg(start_of_msg), .end_of_msg(end_of_msg), .busy(busy),
      .msg_count(msg_count), .abort_count(abort_count)
   );

   itch_add_order_encoder #(.GAP_CYCLES(4)) u_gap (
      .clk(clk), .rst(rst), .in_valid(g_in_valid), .in_ready(g_in_ready),
      .stock_locate(fld.sl), .tracking_number(fld.tn), .timestamp(fld.ts),
      .order_ref(fld.oref), .side(fld.side), .shares(fld.shares),
      .stock(fld.stock), .price(fld.price), .abort(g_abort), .out_ready(g_out_ready),
      .valid_out(g_valid_out), .byte_out(g_byte_out), .byte_index(g_byte_index),
      .start_of_msg(g_start), .end_of_msg(g_end), .busy(g_busy),
      .msg_count(g_msg_count), .abort_count(g_abort_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Scoreboard monitor: one pop per transferred byte.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && valid_out && out_ready) begin
         n_bytes++;
         if (start_of_msg) st_cyc.push_back(cyc);
         if (q.size() == 0) begin
            check("extra_byte", 64'(valid_out), 64'd0);
         end else begin
            e = q.pop_front();
            check("byte_out", 64'(byte_out), 64'(e.b));
            check("byte_index", 64'(byte_index), 64'(e.idx));
            check("start_of_msg", 64'(start_of_msg), 64'(e.idx == 0));
            check("end_of_msg", 64'(end_of_msg), 64'(e.idx == 35));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic fields_t rand_fields();
      fields_t f;
      f.sl     = 16'($urandom);
      f.tn     = 16'($urandom);
      f.ts     = {16'($urandom), $urandom};
      f.oref   = {$urandom, $urandom};
      f.side   = ($urandom_range(0, 1) == 1) ? 8'h42 : 8'h53;
      f.shares = $urandom;
      f.stock  = {$urandom, $urandom};
      f.price  = $urandom;
      return f;
   endfunction

   task automatic push_msg(input logic [287:0] pk);
      for (int i = 0; i < 36; i++) begin
         q.push_back('{b: pk[287 - 8*i -: 8], idx: IW'(i)});
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      q.delete();
      rst = 1'b0;
      tick();
   endtask

   // Presents a bundle and returns at posedge+1 after the accepting edge.
   task automatic send(input fields_t f);
      bit acc;
      bit ok;
      fld = f;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) ok = 1'b1;
      end
      if (!ok) check("accept_timeout", 64'(in_ready), 64'd1);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && q.size() != 0; i++) tick();
      check("drain", 64'(q.size()), 64'd0);
   endtask

   task automatic wait_index(input int idx);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (valid_out && (byte_index == IW'(idx))) ok = 1'b1;
         else tick();
      end
      if (!ok) check("wait_index_timeout", 64'(byte_index), 64'(idx));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      fields_t f;
      logic [287:0] pk;
      int gap_cnt;
      bit seen;

      fld = '0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
      g_in_valid = 1'b0; g_abort = 1'b0; g_out_ready = 1'b1;

      // Reset values while rst is high.
      tick();
      tick();
      check("rst_valid_out", 64'(valid_out), 0);
      check("rst_byte_out", 64'(byte_out), 0);
      check("rst_byte_index", 64'(byte_index), 0);
      check("rst_start", 64'(start_of_msg), 0);
      check("rst_end", 64'(end_of_msg), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_msg_count", 64'(msg_count), 0);
      check("rst_abort_count", 64'(abort_count), 0);
      check("rst_in_ready", 64'(in_ready), 0);
      rst = 1'b0;
      tick();
      check("post_rst_in_ready", 64'(in_ready), 1);

      // GAP_CYCLES=4 instance: in_ready low exactly 4 cycles after each end byte.
      g_in_valid = 1'b1;
      for (int m = 0; m < 2; m++) begin
         seen = 1'b0;
         for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (g_valid_out && g_end && g_out_ready) seen = 1'b1;
         end
         check("gap_end_seen", 64'(seen), 1);
         gap_cnt = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) check("gap_valid_low", 64'(g_valid_out), 0);
            if (g_in_ready) break;
            gap_cnt++;
         end
         check("gap_len", 64'(gap_cnt), 4);
      end
      g_in_valid = 1'b0;
      check("gap_msg_count", 64'(g_msg_count), 2);

      // Test 1: single message with the reference fields.
      do_reset();
      f.sl = 16'h0102; f.tn = 16'h0304; f.ts = 48'h0A0B0C0D0E0F;
      f.oref = 64'h1122334455667788; f.side = 8'h42; f.shares = 32'h00000064;
      f.stock = 64'h4141504C20202020; f.price = 32'h0012D687;
      n_bytes = 0;
      send(f);
      push_msg(288'h41_0102_0304_0A0B0C0D0E0F_1122334455667788_42_00000064_4141504C20202020_0012D687);
      in_valid = 1'b0;
      fld = rand_fields();   // must not affect the message in flight
      drain(100);
      check("t1_bytes", 64'(n_bytes), 36);
      check("t1_msg_count", 64'(msg_count), 1);
      check("t1_busy_idle", 64'(busy), 0);

      // Test 2: backpressure for 5 cycles at index 10.
      do_reset();
      f = rand_fields();
      pk = {8'h41, f};
      n_bytes = 0;
      send(f);
      push_msg(pk);
      in_valid = 1'b0;
      wait_index(10);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", 64'(valid_out), 1);
         check("bp_byte", 64'(byte_out), 64'(pk[287 - 80 -: 8]));
         check("bp_index", 64'(byte_index), 10);
      end
      out_ready = 1'b1;
      drain(100);
      check("bp_bytes", 64'(n_bytes), 36);
      check("bp_msg_count", 64'(msg_count), 1);

      // Test 3: back-to-back bundles, in_valid held high.
      do_reset();
      st_cyc.delete();
      n_bytes = 0;
      for (int k = 0; k < 3; k++) begin
         f = rand_fields();
         send(f);
         push_msg({8'h41, f});
      end
      in_valid = 1'b0;
      drain(200);
      check("b2b_bytes", 64'(n_bytes), 108);
      check("b2b_msg_count", 64'(msg_count), 3);
      check("b2b_starts", 64'(st_cyc.size()), 3);
      if (st_cyc.size() == 3) begin
         check("b2b_spacing1", 64'(st_cyc[1] - st_cyc[0]), 37);
         check("b2b_spacing2", 64'(st_cyc[2] - st_cyc[1]), 37);
      end

      // Test 4: abort at index 20, then a fresh message; abort on end byte ignored.
      do_reset();
      f = rand_fields();
      send(f);
      push_msg({8'h41, f});
      in_valid = 1'b0;
      wait_index(20);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      q.delete();
      check("abort_valid_drop", 64'(valid_out), 0);
      check("abort_count", 64'(abort_count), 1);
      check("abort_msg_count", 64'(msg_count), 0);
      f = rand_fields();
      abort = 1'b1;          // abort in IDLE must not block the accept
      send(f);
      abort = 1'b0;
      push_msg({8'h41, f});
      in_valid = 1'b0;
      check("abort_next_byte", 64'(byte_out), 64'h41);
      check("abort_next_index", 64'(byte_index), 0);
      check("abort_next_start", 64'(start_of_msg), 1);
      wait_index(35);
      abort = 1'b1;          // coincides with the end-byte transfer
      tick();
      abort = 1'b0;
      check("end_abort_drain", 64'(q.size()), 0);
      check("end_abort_msg_count", 64'(msg_count), 1);
      check("end_abort_abort_count", 64'(abort_count), 1);

      // Test 5: reset at index 15.
      f = rand_fields();
      send(f);
      push_msg({8'h41, f});
      in_valid = 1'b0;
      wait_index(15);
      rst = 1'b1;
      tick();
      q.delete();
      check("mid_rst_valid", 64'(valid_out), 0);
      check("mid_rst_byte", 64'(byte_out), 0);
      check("mid_rst_index", 64'(byte_index), 0);
      check("mid_rst_start", 64'(start_of_msg), 0);
      check("mid_rst_end", 64'(end_of_msg), 0);
      check("mid_rst_busy", 64'(busy), 0);
      check("mid_rst_in_ready", 64'(in_ready), 0);
      check("mid_rst_msg_count", 64'(msg_count), 0);
      check("mid_rst_abort_count", 64'(abort_count), 0);
      rst = 1'b0;
      tick();
      check("mid_rst_ready_after", 64'(in_ready), 1);
      f = rand_fields();
      send(f);
      push_msg({8'h41, f});
      in_valid = 1'b0;
      drain(100);
      check("post_rst_msg_count", 64'(msg_count), 1);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/itch_add_order_encoder.md
Name: itch_add_order_encoder

Overview:
Serializes one ITCH 5.0 Add Order ('A') message, supplied as parallel fields, into the 36-byte big-endian byte stream that our ITCH decoders and the decoder watchdog consume (valid_out/byte_index style). It is the transmit-side stimulus and loopback source for the decoder pipeline. Field input uses a valid/ready handshake. Byte output supports downstream backpressure and carries explicit start and end markers.

Parameters:
MSG_LEN, 36, bytes per message; fixed by the Add Order layout.
INDEX_WIDTH, 6, width of byte_index.
MSG_TYPE, 8'h41, type byte emitted at index 0.
GAP_CYCLES, 0, idle cycles forced after each completed message (0..15).
CNT_WIDTH, 16, width of msg_count and abort_count.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle
stock_locate  in  16  field
tracking_number  in  16  field
timestamp  in  48  field
order_ref  in  64  field
side  in  8  field, ASCII 'B'/'S', not checked
shares  in  32  field
stock  in  64  field, ASCII, space padded
price  in  32  field
abort  in  1  discard the message in flight
out_ready  in  1  downstream accepts byte
valid_out  out  1  byte_out valid
byte_out  out  8  serialized byte
byte_index  out  INDEX_WIDTH  position of byte_out in message, 0..MSG_LEN-1
start_of_msg  out  1  high with index-0 byte
end_of_msg  out  1  high with index MSG_LEN-1 byte
busy  out  1  state != IDLE
msg_count  out  CNT_WIDTH  completed messages, wraps
abort_count  out  CNT_WIDTH  aborted messages, wraps

Behaviour:
- Byte order on the wire, MSB first per field: type, stock_locate, tracking_number, timestamp, order_ref, side, shares, stock, price. Total 1+2+2+6+8+1+4+8+4 = 36.
- FSM states:
  - IDLE: in_ready=1, valid_out=0.
  - SEND: valid_out=1.
  - GAP: counts GAP_CYCLES.
- IDLE: on in_valid && in_ready, load a 288-bit shift register {MSG_TYPE, fields}, set index to 0, go to SEND. The first byte is valid on the next cycle (1-cycle latency).
- SEND:
  - byte_out = shift register [287:280]. All outputs are registered.
  - While out_ready=0, valid_out, byte_out, byte_index, start_of_msg and end_of_msg hold stable.
  - A byte transfers on valid_out && out_ready; on transfer, shift left 8 and increment index.
  - start_of_msg = (index==0); end_of_msg = (index==MSG_LEN-1).
  - On transfer of the end byte: msg_count+1, then go to GAP if GAP_CYCLES>0, else IDLE.
- GAP: valid_out=0, in_ready=0. After GAP_CYCLES cycles, go to IDLE.
- Throughput: with out_ready held high and GAP_CYCLES=0, a message occupies 37 cycles (36 bytes + 1 IDLE accept cycle). The encoder never accepts a new bundle during SEND.
- byte_index never repeats within a message while valid_out is high, unless out_ready is low. This guarantees the watchdog does not flag a stall under continuous out_ready.
- abort:
  - In SEND or GAP, the next state is IDLE and valid_out drops the following cycle. In SEND, abort_count+1 and msg_count is unchanged.
  - abort on the same cycle as the end-byte transfer: the transfer completes, msg_count+1, abort is ignored.
  - In IDLE, abort has no effect and is ignored for the accept decision (accept still occurs).
- Input fields are sampled only on accept; later changes are ignored.
- Counters wrap modulo 2^CNT_WIDTH.
- Reset (any state, including mid-message): state IDLE, in_ready=0 during the reset cycle and 1 after, valid_out=0, byte_out=0, byte_index=0, start_of_msg=0, end_of_msg=0, busy=0, msg_count=0, abort_count=0. A message in flight is dropped silently and abort_count does not increment.

Test Plan:
- Single message, out_ready=1. Fields: stock_locate=16'h0102, tracking_number=16'h0304, timestamp=48'h0A0B0C0D0E0F, order_ref=64'h1122334455667788, side=8'h42, shares=32'h00000064, stock="AAPL    ", price=32'h0012D687.
  Required: 36 consecutive bytes 41 01 02 03 04 0A..0F 11..88 42 00 00 00 64 41 41 50 4C 20 20 20 20 00 12 D6 87; byte_index 0..35; start_of_msg only at index 0, end_of_msg only at index 35; msg_count=1.
- Backpressure: out_ready low for 5 cycles at index 10 -> byte_out/byte_index hold at the index-10 value, no byte skipped or duplicated; total bytes=36.
- Back-to-back: in_valid held high for 3 bundles, GAP_CYCLES=0 -> 3 messages, each starting 37 cycles apart; msg_count=3.
- GAP_CYCLES=4 -> in_ready low for exactly 4 cycles after each end byte.
- abort asserted at index 20 -> valid_out low the next cycle, abort_count=1, msg_count unchanged. The next message starts at index 0 with byte 41.
- rst asserted at index 15 -> all outputs at reset values the next cycle, both counters 0, in_ready=1 after rst deasserts.
